// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// Optional feature macro: SYSTOLIC_FEEDER_CLEAR_EN (adds the accumulator CLEAR phase).
package systolic_pkg;

    localparam int OPERAND_BITS = 8;
    localparam int ACC_BITS     = 16;

    typedef logic signed [OPERAND_BITS-1:0] operand_t;
    typedef logic signed [ACC_BITS-1:0]     acc_t;

`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_STREAM,
        ST_DONE
    } feeder_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } feeder_state_t;
`endif

    // Number of cycles the skewed wavefront needs to cross a dim x dim array.
    function automatic int stream_len(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_buf.sv
// DIM x DIM operand buffer: row-wide write port, diagonal (skewed) read port.
// Lane i of the read port returns mem[t-i][i], or zero when t-i is outside the tile.
module systolic_skew_buf
    import systolic_pkg::*;
#(
    parameter int DIM = 8,
    parameter int W   = 8,
    parameter int RW  = $clog2(DIM),
    parameter int TW  = $clog2(3 * DIM - 2)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [RW-1:0]         wr_row,
    input  logic [DIM-1:0][W-1:0] wr_data,
    input  logic [TW-1:0]         t,
    output logic [DIM-1:0][W-1:0] rd_data
);

    logic [DIM-1:0][W-1:0] mem [DIM];

    // Capture one beat as a whole row; contents need no reset since a job always fills every row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [TW-1:0] diff;
        logic [W-1:0]  lane;

        // Diagonal read: lane i lags lane 0 by i cycles, padded with true zeros.
        always_comb begin
            diff = t - TW'(i);
            lane = '0;
            if ((t >= TW'(i)) && (diff < TW'(DIM))) begin
                lane = mem[diff[RW-1:0]][i];
            end
        end

        assign rd_data[i] = lane;
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for the systolic MAC array: loads an A and B tile over a
// valid/ready stream, optionally clears the C accumulators, then streams the
// skewed lanes with en asserted for exactly the compute window.
// Optional feature macro: SYSTOLIC_FEEDER_CLEAR_EN (CLEAR phase before STREAM).
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIM-1:0][BITS_AB-1:0] in_a,
    input  logic [DIM-1:0][BITS_AB-1:0] in_b,
    output logic                        busy,
    output logic                        done,
    output logic [DIM-1:0][BITS_AB-1:0] A,
    output logic [DIM-1:0][BITS_AB-1:0] B,
    output logic                        en,
    output logic                        WrEn,
    output logic [$clog2(DIM)-1:0]      Crow,
    output logic [DIM-1:0][BITS_C-1:0]  Cin
);

    localparam int RW   = $clog2(DIM);
    localparam int KW   = $clog2(DIM + 1);
    localparam int SLEN = stream_len(DIM);
    localparam int TW   = $clog2(SLEN);

    feeder_state_t state;
    logic [KW-1:0] k;
    logic [TW-1:0] t;
    logic          load_fire;
    logic [DIM-1:0][BITS_AB-1:0] diag_a;
    logic [DIM-1:0][BITS_AB-1:0] diag_b;

`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    logic [RW-1:0] r;
    logic          wr_en_q;
`endif

    assign load_fire = (state == ST_LOAD) && in_valid;

    // Control FSM; every control output is a flop updated together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            k        <= '0;
            t        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            en       <= 1'b0;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
            r        <= '0;
            wr_en_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        k        <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (k == KW'(DIM - 1)) begin
                            k        <= '0;
                            in_ready <= 1'b0;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
                            state    <= ST_CLEAR;
                            r        <= '0;
                            wr_en_q  <= 1'b1;
`else
                            state    <= ST_STREAM;
                            t        <= '0;
                            en       <= 1'b1;
`endif
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
                ST_CLEAR: begin
                    if (r == RW'(DIM - 1)) begin
                        state   <= ST_STREAM;
                        r       <= '0;
                        wr_en_q <= 1'b0;
                        t       <= '0;
                        en      <= 1'b1;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
`endif
                ST_STREAM: begin
                    if (t == TW'(SLEN - 1)) begin
                        state <= ST_DONE;
                        t     <= '0;
                        en    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    systolic_skew_buf #(.DIM(DIM), .W(BITS_AB), .RW(RW), .TW(TW)) u_buf_a (
        .clk     (clk),
        .wr_en   (load_fire),
        .wr_row  (k[RW-1:0]),
        .wr_data (in_a),
        .t       (t),
        .rd_data (diag_a)
    );

    systolic_skew_buf #(.DIM(DIM), .W(BITS_AB), .RW(RW), .TW(TW)) u_buf_b (
        .clk     (clk),
        .wr_en   (load_fire),
        .wr_row  (k[RW-1:0]),
        .wr_data (in_b),
        .t       (t),
        .rd_data (diag_b)
    );

    // Lanes are only live inside the compute window (en mirrors the STREAM state).
    assign A   = en ? diag_a : '0;
    assign B   = en ? diag_b : '0;
    assign Cin = '0;

`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    assign WrEn = wr_en_q;
    assign Crow = r;
`else
    assign WrEn = 1'b0;
    assign Crow = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (DIM=4, 8-bit operands).
// Honors SYSTOLIC_FEEDER_CLEAR_EN the same way the design does.
module tb_systolic_feeder;

    localparam int DIM  = 4;
    localparam int SLEN = 3 * DIM - 2;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic in_ready, busy, done, en, wr_en;
    logic [DIM-1:0][7:0]  in_a, in_b, a_out, b_out;
    logic [1:0]           crow;
    logic [DIM-1:0][15:0] cin;

    logic [7:0] ta [DIM][DIM];
    logic [7:0] tb [DIM][DIM];

    int total = 0;
    int bad   = 0;

    systolic_feeder #(.BITS_AB(8), .BITS_C(16), .DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .busy     (busy),
        .done     (done),
        .A        (a_out),
        .B        (b_out),
        .en       (en),
        .WrEn     (wr_en),
        .Crow     (crow),
        .Cin      (cin)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop if the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int k, input logic v);
        in_valid = v;
        for (int i = 0; i < DIM; i++) begin
            in_a[i] = ta[i][k];
            in_b[i] = tb[k][i];
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_all;
        for (int k = 0; k < DIM; k++) begin
            set_beat(k, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic skip_clear;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
        repeat (DIM) tick();
`endif
    endtask

    function automatic logic [DIM-1:0][7:0] exp_a_row(input int t);
        logic [DIM-1:0][7:0] row;
        for (int i = 0; i < DIM; i++) begin
            row[i] = ((t - i >= 0) && (t - i < DIM)) ? ta[i][t-i] : 8'h00;
        end
        return row;
    endfunction

    function automatic logic [DIM-1:0][7:0] exp_b_row(input int t);
        logic [DIM-1:0][7:0] row;
        for (int j = 0; j < DIM; j++) begin
            row[j] = ((t - j >= 0) && (t - j < DIM)) ? tb[t-j][j] : 8'h00;
        end
        return row;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        #3;
        total++;
        if ({in_ready, busy, done, en, wr_en} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000", {in_ready, busy, done, en, wr_en});
        end
        total++;
        if ({a_out, b_out, crow, cin} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data got A=%h B=%h Crow=%h Cin=%h want all 0", a_out, b_out, crow, cin);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int en_cycles = 0;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                ta[i][k] = 8'(10 * i + k + 1);
                tb[k][i] = 8'(-(10 * k + i + 1));
            end
        do_start();
        total++;
        if ({in_ready, busy} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL start_handshake got=%b want=11", {in_ready, busy});
        end
        load_all();
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
        for (int r = 0; r < DIM; r++) begin
            total++;
            if (wr_en !== 1'b1 || crow !== 2'(r) || en !== 1'b0 || cin !== '0) begin
                bad++;
                $display("[TB] FAIL clear_row r=%0d got WrEn=%b Crow=%0d en=%b want 1,%0d,0", r, wr_en, crow, en, r);
            end
            tick();
        end
`endif
        for (int t = 0; t < SLEN; t++) begin
            total++;
            if (en !== 1'b1 || wr_en !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL basic_en t=%0d got en=%b WrEn=%b in_ready=%b want 1,0,0", t, en, wr_en, in_ready);
            end
            total++;
            if (a_out !== exp_a_row(t) || b_out !== exp_b_row(t)) begin
                bad++;
                $display("[TB] FAIL basic_lanes t=%0d got A=%h B=%h want A=%h B=%h", t, a_out, b_out, exp_a_row(t), exp_b_row(t));
            end
            if (t == 0) begin
                total++;
                if (a_out !== 32'h0000_0001 || b_out !== 32'h0000_00FF) begin
                    bad++;
                    $display("[TB] FAIL basic_t0 got A=%h B=%h want A=00000001 B=000000ff", a_out, b_out);
                end
            end
            if (t == 1) begin
                total++;
                if (a_out !== 32'h0000_0B02 || b_out !== 32'h0000_FEF5) begin
                    bad++;
                    $display("[TB] FAIL basic_t1 got A=%h B=%h want A=00000b02 B=0000fef5", a_out, b_out);
                end
            end
            if (t == 3) begin
                total++;
                if (a_out !== 32'h1F16_0D04) begin
                    bad++;
                    $display("[TB] FAIL basic_t3 got A=%h want A=1f160d04", a_out);
                end
            end
            if (t == SLEN - 1) begin
                total++;
                if (a_out !== '0 || b_out !== '0) begin
                    bad++;
                    $display("[TB] FAIL basic_tlast got A=%h B=%h want 0", a_out, b_out);
                end
            end
            if (en === 1'b1) en_cycles++;
            tick();
        end
        total++;
        if ({done, en, busy} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL basic_done got done,en,busy=%b want 101", {done, en, busy});
        end
        total++;
        if (en_cycles != SLEN) begin
            bad++;
            $display("[TB] FAIL basic_en_count got=%0d want=%0d", en_cycles, SLEN);
        end
        tick();
        total++;
        if ({done, busy, a_out, b_out} !== '0) begin
            bad++;
            $display("[TB] FAIL basic_idle got done=%b busy=%b A=%h B=%h want 0", done, busy, a_out, b_out);
        end
    endtask

    task automatic test_backpressure;
        int k = 0;
        int cyc = 0;
        logic v;
        for (int i = 0; i < DIM; i++)
            for (int kk = 0; kk < DIM; kk++) begin
                ta[i][kk] = 8'(5 * kk + i + 40);
                tb[kk][i] = 8'(7 * i - kk);
            end
        do_start();
        while (k < DIM && cyc < 60) begin
            v = ((cyc % 3) == 0);
            set_beat(k, v);
            total++;
            if (en !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL bp_loading cyc=%0d got en=%b in_ready=%b want 0,1", cyc, en, in_ready);
            end
            tick();
            if (v) k++;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (k != DIM || in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_accept got beats=%0d in_ready=%b want %0d,0", k, in_ready, DIM);
        end
        skip_clear();
        for (int t = 0; t < SLEN; t++) begin
            total++;
            if (en !== 1'b1 || a_out !== exp_a_row(t) || b_out !== exp_b_row(t)) begin
                bad++;
                $display("[TB] FAIL bp_lanes t=%0d got en=%b A=%h B=%h want 1 A=%h B=%h", t, en, a_out, b_out, exp_a_row(t), exp_b_row(t));
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_done got=%b want=1", done);
        end
        tick();
    endtask

    task automatic test_ignored_start;
        int en_cycles = 0;
        start = 1'b1;
        tick();
        load_all();
        skip_clear();
        for (int t = 0; t < SLEN; t++) begin
            if (en === 1'b1) en_cycles++;
            total++;
            if (in_ready !== 1'b0 || a_out !== exp_a_row(t)) begin
                bad++;
                $display("[TB] FAIL ign_stream t=%0d got in_ready=%b A=%h want 0 A=%h", t, in_ready, a_out, exp_a_row(t));
            end
            tick();
        end
        total++;
        if (en_cycles != SLEN || done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ign_window got en_cycles=%0d done=%b want %0d,1", en_cycles, done, SLEN);
        end
        tick();
        total++;
        if ({busy, in_ready} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL ign_idle got busy,in_ready=%b want 00", {busy, in_ready});
        end
        tick();
        total++;
        if ({busy, in_ready} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL ign_restart got busy,in_ready=%b want 11", {busy, in_ready});
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                ta[i][k] = 8'(16 * i + k);
                tb[k][i] = 8'(16 * k + i + 100);
            end
        do_start();
        load_all();
        skip_clear();
        repeat (5) tick();
        total++;
        if (en !== 1'b1 || a_out !== exp_a_row(5)) begin
            bad++;
            $display("[TB] FAIL mid_t5 got en=%b A=%h want 1 A=%h", en, a_out, exp_a_row(5));
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, busy, done, en, wr_en, crow, a_out, b_out, cin} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_abort got busy=%b en=%b A=%h B=%h want all 0", busy, en, a_out, b_out);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                ta[i][k] = 8'(100 + i + 4 * k);
                tb[k][i] = 8'(200 - 3 * i - k);
            end
        do_start();
        load_all();
        skip_clear();
        for (int t = 0; t < SLEN; t++) begin
            total++;
            if (en !== 1'b1 || a_out !== exp_a_row(t) || b_out !== exp_b_row(t)) begin
                bad++;
                $display("[TB] FAIL mid_newjob t=%0d got en=%b A=%h B=%h want 1 A=%h B=%h", t, en, a_out, b_out, exp_a_row(t), exp_b_row(t));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_signed;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                ta[i][k] = 8'h80;
                tb[k][i] = 8'h80;
            end
        do_start();
        load_all();
        skip_clear();
        for (int t = 0; t < SLEN; t++) begin
            if (t == 0) begin
                total++;
                if (a_out !== 32'h0000_0080 || b_out !== 32'h0000_0080) begin
                    bad++;
                    $display("[TB] FAIL signed_t0 got A=%h B=%h want 00000080", a_out, b_out);
                end
            end
            if (t == 3) begin
                total++;
                if (a_out !== 32'h8080_8080 || b_out !== 32'h8080_8080) begin
                    bad++;
                    $display("[TB] FAIL signed_t3 got A=%h B=%h want 80808080", a_out, b_out);
                end
            end
            if (t == 6) begin
                total++;
                if (a_out !== 32'h8000_0000 || b_out !== 32'h8000_0000) begin
                    bad++;
                    $display("[TB] FAIL signed_t6 got A=%h B=%h want 80000000", a_out, b_out);
                end
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || a_out !== '0) begin
            bad++;
            $display("[TB] FAIL signed_done got done=%b A=%h want 1,0", done, a_out);
        end
        tick();
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_signed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand sequencer for the systolic MAC array. Accepts one DIM×DIM A tile and one DIM×DIM B tile from the host/MMIO side over a valid/ready stream and buffers them. It then drives the array's A/B lane inputs with the diagonal skew the array needs, asserting the array `en` for exactly the compute window. When configured, it also clears the array's C accumulators through the array's row-write port before computing.

## Interface
- `BITS_AB`, default 8: signed operand width.
- `BITS_C`, default 16: accumulator width, used for `Cin`.
- `DIM`, default 8: array dimension, ≥2.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: begin a tile job; sampled only in IDLE.
- `in_valid` in, 1: load beat valid.
- `in_ready` out, 1: high only in LOAD.
- `in_a` in, DIM×BITS_AB signed: beat k carries A column k, so `in_a[i]`=A[i][k].
- `in_b` in, DIM×BITS_AB signed: beat k carries B row k, so `in_b[j]`=B[k][j].
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse when the compute window ends.
- `A` out, DIM×BITS_AB signed: to array A lanes.
- `B` out, DIM×BITS_AB signed: to array B lanes.
- `en` out, 1: array enable.
- `WrEn` out, 1: array C row write enable.
- `Crow` out, $clog2(DIM): array C row select.
- `Cin` out, DIM×BITS_C signed: array C write data.

## Operation
- States: IDLE, LOAD, CLEAR (present only when the macro is defined), STREAM, DONE.
- **IDLE:**
  - `start`=1 → LOAD, with beat counter k=0.
  - `in_valid` is ignored.
- **LOAD:**
  - A beat is accepted on `in_valid & in_ready`. It is stored to bufA[k]/bufB[k], then k++.
  - Stalls indefinitely while `in_valid`=0.
  - The accept that makes k=DIM moves to CLEAR, or to STREAM when CLEAR is compiled out.
- **CLEAR:**
  - Lasts DIM cycles, with row counter r=0..DIM-1.
  - Drives `WrEn`=1, `Crow`=r, `Cin`=all 0, `en`=0.
  - After r=DIM-1 → STREAM.
- **STREAM:**
  - Lasts exactly 3·DIM−2 cycles, t=0..3·DIM−3, with `en`=1 throughout.
  - `A[i]`=bufA[t−i][i] when 0≤t−i<DIM, otherwise 0.
  - `B[j]`=bufB[t−j][j] when 0≤t−j<DIM, otherwise 0.
  - After t=3·DIM−3 → DONE.
- **DONE:**
  - One cycle with `done`=1 and `en`=0, then → IDLE.
- `start` outside IDLE is ignored. No queuing.
- Lane values are passed through unmodified. There is no arithmetic and no width change; zero padding is a true signed 0.
- Outside CLEAR: `WrEn`=0, `Crow`=0, `Cin`=0.
- Outside STREAM: `A`=0, `B`=0, `en`=0.

## Timing
- All outputs are registered or decoded from registered state. No input→output combinational path.
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `A`/`B`=0, `en`=0, `WrEn`=0, `Crow`=0, `Cin`=0, state=IDLE, counters=0. Buffer contents are don't-care.
- `start` sampled at edge e → `in_ready`=1 and `busy`=1 from cycle e+1.
- The final beat accepted at edge f:
  - With CLEAR: `WrEn` rises at cycle f+1, and stream cycle t=0 is at f+1+DIM.
  - Without CLEAR: stream cycle t=0 is at f+1.
- `done` is high in the cycle after the last `en`=1 cycle. `busy` drops the cycle after `done`.
- Minimum job length, no backpressure, CLEAR enabled: 1+DIM+DIM+(3·DIM−2)+1 cycles from `start`.
- Reset mid-job: the job is aborted immediately and all outputs take their reset values. Partial buffer data is never streamed.
- The tile must not change during STREAM. Buffers are written only in LOAD.

## Configuration
- `SYSTOLIC_FEEDER_CLEAR_EN` defined:
  - The CLEAR state exists and zeroes all DIM accumulator rows before every STREAM.
- Undefined:
  - LOAD goes directly to STREAM, and results accumulate onto existing C.
  - `WrEn`, `Crow` and `Cin` are tied to 0.
  - The row counter is removed.

## Structure
- Shared package `systolic_pkg`:
  - The state enum type (feeder_state_t).
  - The localparam function `stream_len(DIM)` = 3·DIM−2.
  - Typedefs for signed operand and accumulator lanes, parameterised through package parameters matching `BITS_AB`/`BITS_C`.
- One natural sub-module: `systolic_skew_buf`.
  - A DIM×DIM register buffer with a write port (row index, DIM lanes) and a diagonal read port (t → lane i = buf[t−i][i] or 0).
  - Instantiated twice, once for A and once for B.
- The FSM and counters stay in `systolic_feeder`.

## Test plan
- **Basic job:** DIM=2, CLEAR enabled. Beats {a:(1,3), b:(5,6)}, then {a:(2,4), b:(7,8)}.
  - Two CLEAR cycles with `Crow`=0,1 and `WrEn`=1.
  - STREAM: t0 A=(1,0) B=(5,0); t1 A=(2,3) B=(7,6); t2 A=(0,4) B=(0,8); t3 all zeros.
  - `done` follows. With the array attached, C=[[19,22],[43,50]].
- **Backpressure:** DIM=8, `in_valid` toggled 1,0,0,1… → exactly 8 beats accepted, buffer order preserved, `en` stays 0 until loading completes.
- **Ignored start:** `start` held high through the whole job → no second job. A new job starts only from IDLE, the cycle after `busy` falls.
- **Reset mid-job:** `rst` pulsed during STREAM at t=5 → all outputs 0 in the same cycle. A subsequent job streams only the new tile.
- **Macro off:** DIM=4 → stream t=0 occurs the cycle after the 4th beat. `WrEn` is never 1, and `en` is high for exactly 10 cycles.
- **Signed extremes:** all operands −128 → lanes carry −128 unchanged, and padding lanes are exactly 0.
